spi_ram_master_seq: RTL and testbench
=====================================

// Module: spi_ram_master_seq
// PURPOSE
//  Host-side SPI master sequencer for the SPI-slave/single-port-RAM wrapper. Accepts one
//  byte-wide write or read request at a time and expands it into the slave's frame sequence:
//  address frame, then data frame, with MISO capture for reads. Sits between a host/CPU
//  request port and the wrapper's SS_n/MOSI/MISO pins, and shares the wrapper's clock.
// PARAMETERS
//  ADDR_SIZE   8  address and data payload width; frame length FRAME = ADDR_SIZE+3 bits
//  GAP_CYCLES  4  SS_n-high cycles after every frame; legal range >= 1
//  READ_LAT    2  cycles after the last read-data-frame bit before the first MISO sample
// PORTS
//  clk        in   1          system clock; all logic on posedge
//  rst_n      in   1          asynchronous active-low reset
//  req_valid  in   1          host request strobe
//  req_ready  out  1          block idle; a request is accepted on req_valid & req_ready
//  req_wr     in   1          1 = write, 0 = read
//  req_addr   in   ADDR_SIZE  RAM address
//  req_wdata  in   ADDR_SIZE  write data; ignored for reads
//  rsp_valid  out  1          one-cycle pulse; read data available
//  rsp_rdata  out  ADDR_SIZE  read data; held until the next read completes
//  busy       out  1          equals ~req_ready
//  SS_n       out  1          slave select to the wrapper
//  MOSI       out  1          serial data to the wrapper
//  MISO       in   1          serial data from the wrapper
// BEHAVIOUR
//  Reset (async): SS_n=1, MOSI=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, state IDLE.
//  All outputs are registered. Reset during a frame aborts it immediately (SS_n=1).
//  Frame: FRAME consecutive cycles with SS_n=0, MOSI MSB first: {cmd[1], cmd[1:0], payload}.
//   Commands: 00 write address, 01 write data, 10 read address, 11 read data (payload 0).
//  FSM: IDLE -> ADDR -> GAP_A -> DATA -> (write: GAP_D | read: RWAIT -> RCAP -> GAP_D) -> IDLE.
//   IDLE: req_ready=1. On accept, latch wr/addr/wdata; SS_n falls the next cycle (ADDR).
//   ADDR: FRAME bits of cmd 00/10 with req_addr. GAP_A: SS_n=1 for GAP_CYCLES.
//   DATA: FRAME bits of cmd 01 with wdata, or 11 with payload 0.
//   RWAIT: SS_n stays 0, MOSI=0 for READ_LAT cycles. RCAP: sample MISO on ADDR_SIZE
//    consecutive posedges, MSB first. On leaving RCAP: SS_n=1, rsp_rdata updated,
//    rsp_valid=1 for exactly that cycle.
//   GAP_D: SS_n=1 for GAP_CYCLES, then IDLE; req_ready rises in the first IDLE cycle.
//  Latency from accept to req_ready, counted in cycles:
//   write = 2*(FRAME+GAP_CYCLES)+1
//   read  = 2*FRAME+2*GAP_CYCLES+READ_LAT+ADDR_SIZE+1
//  req_valid while busy is ignored (not queued); latched fields do not change mid-operation.
//  MOSI=0 whenever SS_n=1. Bit and gap counters are sized for max(FRAME, GAP_CYCLES,
//  READ_LAT, ADDR_SIZE) and never wrap.
// CONFIGURATION
//  SPI_SEQ_ADDR_CACHE_EN defined: two registers hold the last write address and the last read
//   address sent, each with a valid bit. A request whose address matches the valid cached
//   address of the same type skips ADDR and GAP_A, going IDLE -> DATA. Both valid bits are
//   cleared on reset. Each valid bit is set when its ADDR frame completes; an aborted frame
//   leaves it cleared. Write latency with a hit = FRAME+GAP_CYCLES+1.
//  Undefined: every request sends its address frame; no cache registers are built.
// TESTING (bench includes the SPI_Wrapper slave and RAM; defaults unless stated)
//  1 write addr 0xFF data 0xA5 -> MOSI frames 0_00_11111111, then 0_01_10100101;
//    4-cycle gaps; req_ready returns after 31 cycles.
//  2 read addr 0xFF after test 1 -> frames 1_10_11111111, then 1_11_00000000;
//    rsp_valid single pulse with rsp_rdata=0xA5; latency 41 cycles.
//  3 req_valid held high through the op with changing addr/data -> only first accepted;
//    frames carry the latched values.
//  4 rst_n low for 1 cycle mid DATA frame -> SS_n=1 and MOSI=0 immediately; next request
//    restarts with a full ADDR frame (cache cleared, if built).
//  5 with SPI_SEQ_ADDR_CACHE_EN: two writes to 0x10 -> second skips ADDR (latency 16 cycles);
//    read 0x10 still sends ADDR; write 0x11 sends ADDR.
//  6 GAP_CYCLES=1, READ_LAT=0 -> single-cycle SS_n-high gaps; MISO sampled in the
//    cycle right after the last DATA bit.

Source files
------------

// File: rtl/spi_ram_master_seq.sv
// SPI master sequencer: expands one host write/read into address and data frames for the SPI-RAM slave.
// Latency: write 2*(FRAME+GAP_CYCLES)+1 cycles, read 2*FRAME+2*GAP_CYCLES+READ_LAT+ADDR_SIZE+1 cycles.
// Backpressure: req_ready is low for the whole operation; req_valid while busy is ignored, not queued.
//
// Ports: clk/rst_n (async active-low); host side req_valid/req_ready/req_wr/req_addr/req_wdata,
// rsp_valid/rsp_rdata, busy; SPI side SS_n/MOSI (out) and MISO (in).
// Optional build macro SPI_SEQ_ADDR_CACHE_EN: remembers the last write and last read address
// sent, so a repeat address of the same type skips the ADDR frame and its gap.
module spi_ram_master_seq #(
    parameter int ADDR_SIZE  = 8,
    parameter int GAP_CYCLES = 4,
    parameter int READ_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [ADDR_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_rdata,
    output logic                 busy,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int FRAME = ADDR_SIZE + 3;
    localparam int MAX1  = (FRAME > GAP_CYCLES) ? FRAME : GAP_CYCLES;
    localparam int MAX2  = (MAX1 > READ_LAT) ? MAX1 : READ_LAT;
    localparam int MAXC  = (MAX2 > ADDR_SIZE) ? MAX2 : ADDR_SIZE;
    localparam int CNT_W = $clog2(MAXC + 1);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RL_LAST    = CNT_W'((READ_LAT > 0) ? READ_LAT - 1 : 0);
    localparam logic [CNT_W-1:0] DW_LAST    = CNT_W'(ADDR_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_GAP_A, S_DATA, S_RWAIT, S_RCAP, S_GAP_D
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   wr_q, wr_d;
    logic [ADDR_SIZE-1:0]   wdata_q, wdata_d;
    logic [FRAME-1:0]       shift_q, shift_d;
    logic                   ss_n_q, ss_n_d;
    logic                   mosi_q, mosi_d;
    logic                   req_ready_q, req_ready_d;
    logic                   busy_q, busy_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [ADDR_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_SIZE-2:0]   rsh_q, rsh_d;
    logic                   cap_q, cap_d;
    logic                   cap_last_q, cap_last_d;
    logic [ADDR_SIZE-1:0]   cap_word;
    logic                   accept;
    logic                   hit;
`ifdef SPI_SEQ_ADDR_CACHE_EN
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [ADDR_SIZE-1:0]   wc_addr_q, wc_addr_d;
    logic [ADDR_SIZE-1:0]   rc_addr_q, rc_addr_d;
    logic                   wc_vld_q, wc_vld_d;
    logic                   rc_vld_q, rc_vld_d;
`endif

    // Frame layout on the wire, MSB first: {cmd[1], cmd[1:0], payload}.
    function automatic logic [FRAME-1:0] mk_frame(input logic [1:0] cmd,
                                                  input logic [ADDR_SIZE-1:0] pl);
        return {cmd[1], cmd, pl};
    endfunction

    function automatic logic [FRAME-1:0] data_frame(input logic wr,
                                                    input logic [ADDR_SIZE-1:0] wd);
        return wr ? mk_frame(2'b01, wd) : mk_frame(2'b11, '0);
    endfunction

    assign accept   = req_valid & req_ready_q;
    assign cap_word = {rsh_q, MISO};

`ifdef SPI_SEQ_ADDR_CACHE_EN
    assign hit = req_wr ? (wc_vld_q && (wc_addr_q == req_addr))
                        : (rc_vld_q && (rc_addr_q == req_addr));
`else
    assign hit = 1'b0;
`endif

    // Every output flop is loaded from the current state, so pins trail the state by one
    // cycle. MISO capture is delayed a further cycle (cap_q) so the first sample lands in
    // the pin cycle after the last RWAIT cycle seen by the slave.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        shift_d     = shift_q;
        ss_n_d      = 1'b1;
        mosi_d      = 1'b0;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsh_d       = rsh_q;
        cap_d       = (state_q == S_RCAP);
        cap_last_d  = (state_q == S_RCAP) && (cnt_q == DW_LAST);
`ifdef SPI_SEQ_ADDR_CACHE_EN
        addr_d      = addr_q;
        wc_addr_d   = wc_addr_q;
        rc_addr_d   = rc_addr_q;
        wc_vld_d    = wc_vld_q;
        rc_vld_d    = rc_vld_q;
`endif

        case (state_q)
            S_IDLE: begin
                req_ready_d = ~accept;
                if (accept) begin
                    wr_d    = req_wr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
`ifdef SPI_SEQ_ADDR_CACHE_EN
                    addr_d  = req_addr;
`endif
                    if (hit) begin
                        state_d = S_DATA;
                        shift_d = data_frame(req_wr, req_wdata);
                    end else begin
                        state_d = S_ADDR;
                        shift_d = mk_frame(req_wr ? 2'b00 : 2'b10, req_addr);
                    end
                end
            end
            S_ADDR, S_DATA: begin
                ss_n_d  = 1'b0;
                mosi_d  = shift_q[FRAME-1];
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == FRAME_LAST) begin
                    cnt_d = '0;
                    if (state_q == S_ADDR)  state_d = S_GAP_A;
                    else if (wr_q)          state_d = S_GAP_D;
                    else if (READ_LAT > 0)  state_d = S_RWAIT;
                    else                    state_d = S_RCAP;
                end
            end
            S_GAP_A: begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef SPI_SEQ_ADDR_CACHE_EN
                // The last address bit has fully left the pins by the end of this cycle.
                if (cnt_q == '0) begin
                    if (wr_q) begin
                        wc_addr_d = addr_q;
                        wc_vld_d  = 1'b1;
                    end else begin
                        rc_addr_d = addr_q;
                        rc_vld_d  = 1'b1;
                    end
                end
`endif
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                    shift_d = data_frame(wr_q, wdata_q);
                end
            end
            S_RWAIT: begin
                ss_n_d = 1'b0;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == RL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RCAP;
                end
            end
            S_RCAP: begin
                ss_n_d = 1'b0;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == DW_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP_D;
                end
            end
            S_GAP_D: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (cap_q) begin
            rsh_d = cap_word[ADDR_SIZE-2:0];
        end
        if (cap_last_q) begin
            rsp_rdata_d = cap_word;
            rsp_valid_d = 1'b1;
        end

        busy_d = ~req_ready_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            shift_q     <= '0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsh_q       <= '0;
            cap_q       <= 1'b0;
            cap_last_q  <= 1'b0;
`ifdef SPI_SEQ_ADDR_CACHE_EN
            addr_q      <= '0;
            wc_addr_q   <= '0;
            rc_addr_q   <= '0;
            wc_vld_q    <= 1'b0;
            rc_vld_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            shift_q     <= shift_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsh_q       <= rsh_d;
            cap_q       <= cap_d;
            cap_last_q  <= cap_last_d;
`ifdef SPI_SEQ_ADDR_CACHE_EN
            addr_q      <= addr_d;
            wc_addr_q   <= wc_addr_d;
            rc_addr_q   <= rc_addr_d;
            wc_vld_q    <= wc_vld_d;
            rc_vld_q    <= rc_vld_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_ram_master_seq.sv
// Bench for spi_ram_master_seq: a behavioural SPI-RAM slave decodes frames and answers reads;
// expected frames and read responses are queued by the stimulus and popped by a monitor.
// A second instance with GAP_CYCLES=1, READ_LAT=0 checks short gaps and immediate sampling.
module tb_spi_ram_master_seq;

    localparam int FRAME = 11;
    localparam int RL    = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_wr;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy, SS_n, MOSI, MISO;

    logic       req_valid6, req_ready6, req_wr6;
    logic [7:0] req_addr6, req_wdata6;
    logic       rsp_valid6;
    logic [7:0] rsp_rdata6;
    logic       busy6, SS_n6, MOSI6, MISO6;

    int checks = 0;
    int errors = 0;

    logic [FRAME-1:0] exp_frames[$];
    logic [7:0]       exp_rsp[$];

    always #5 clk = ~clk;

    spi_ram_master_seq dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    spi_ram_master_seq #(.ADDR_SIZE(8), .GAP_CYCLES(1), .READ_LAT(0)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid6), .req_ready(req_ready6), .req_wr(req_wr6),
        .req_addr(req_addr6), .req_wdata(req_wdata6),
        .rsp_valid(rsp_valid6), .rsp_rdata(rsp_rdata6), .busy(busy6),
        .SS_n(SS_n6), .MOSI(MOSI6), .MISO(MISO6)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [FRAME-1:0] mkf(input logic [1:0] cmd, input logic [7:0] pl);
        return {cmd[1], cmd, pl};
    endfunction

    // Slave model and scoreboard monitor, sampling on the falling edge.
    initial begin : monitor
        int         bitcnt;
        bit         fdone;
        logic [FRAME-1:0] fsh;
        logic [7:0] mem [256];
        logic [7:0] waddr, raddr, rdout;
        int         miso_wait, miso_idx;
        bit         miso_on, rv_prev;
        bitcnt = 0; fdone = 0; fsh = '0; waddr = '0; raddr = '0; rdout = '0;
        miso_wait = 0; miso_idx = 0; miso_on = 0; rv_prev = 0;
        MISO = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bitcnt = 0; fdone = 0; miso_wait = 0; miso_on = 0; MISO = 1'b0; rv_prev = 0;
            end else begin
                if (miso_wait > 0) begin
                    miso_wait--;
                    if (miso_wait == 0) begin
                        miso_on = 1; miso_idx = 7; MISO = rdout[7];
                    end
                end else if (miso_on) begin
                    if (miso_idx == 0) begin
                        miso_on = 0; MISO = 1'b0;
                    end else begin
                        miso_idx--; MISO = rdout[miso_idx];
                    end
                end
                if (SS_n) begin
                    if (MOSI !== 1'b0) check("mosi_idle", {31'd0, MOSI}, 32'd0);
                    bitcnt = 0; fdone = 0;
                end else if (!fdone) begin
                    fsh = {fsh[FRAME-2:0], MOSI};
                    bitcnt++;
                    if (bitcnt == FRAME) begin
                        fdone = 1;
                        if (exp_frames.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL frame: unexpected frame 0x%0h, none expected", fsh);
                        end else begin
                            check("frame", {21'd0, fsh}, {21'd0, exp_frames.pop_front()});
                        end
                        case (fsh[9:8])
                            2'b00: waddr = fsh[7:0];
                            2'b01: mem[waddr] = fsh[7:0];
                            2'b10: raddr = fsh[7:0];
                            default: begin
                                rdout = mem[raddr];
                                miso_wait = RL + 1;
                            end
                        endcase
                    end
                end
                if (rsp_valid) begin
                    check("rsp_single_pulse", {31'd0, rv_prev}, 32'd0);
                    if (exp_rsp.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rsp: unexpected rsp_valid data 0x%0h", rsp_rdata);
                    end else begin
                        check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rsp.pop_front()});
                    end
                end
                rv_prev = rsp_valid;
            end
        end
    end

    // Issue one request from just after a rising edge; count edges until req_ready returns.
    task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d,
                         input int exp_lat, input bit hold);
        int lat;
        int w;
        w = 0;
        while (!req_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        lat = 0;
        if (!hold) req_valid = 1'b0;
        while (lat < 300) begin
            @(posedge clk); lat++; #1;
            if (req_ready) break;
            if (hold) begin
                req_addr  = req_addr + 8'h11;
                req_wdata = ~req_wdata;
                req_wr    = ~req_wr;
            end
        end
        req_valid = 1'b0;
        check(wr ? "write_latency" : "read_latency", lat, exp_lat);
        check("busy_after_op", {31'd0, busy}, 32'd0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] pat6;
        rst_n = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        req_valid6 = 1'b0; req_wr6 = 1'b0; req_addr6 = '0; req_wdata6 = '0; MISO6 = 1'b0;
        pat6 = 8'hB4;
        repeat (3) @(negedge clk);
        check("rst_ss_n", {31'd0, SS_n}, 32'd1);
        check("rst_mosi", {31'd0, MOSI}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: write 0xFF <- 0xA5
        exp_frames.push_back(11'h0FF); exp_frames.push_back(11'h1A5);
        issue(1'b1, 8'hFF, 8'hA5, 31, 1'b0);
        // 2: read 0xFF
        exp_frames.push_back(11'h6FF); exp_frames.push_back(11'h700);
        exp_rsp.push_back(8'hA5);
        issue(1'b0, 8'hFF, 8'h00, 41, 1'b0);
        // 3: req_valid held with changing fields; only the first request counts
        exp_frames.push_back(mkf(2'b00, 8'h3C)); exp_frames.push_back(mkf(2'b01, 8'h5A));
        issue(1'b1, 8'h3C, 8'h5A, 31, 1'b1);
        exp_frames.push_back(mkf(2'b10, 8'h3C)); exp_frames.push_back(mkf(2'b11, 8'h00));
        exp_rsp.push_back(8'h5A);
        issue(1'b0, 8'h3C, 8'h00, 41, 1'b0);

        // 4: reset pulse in the middle of the DATA frame
        exp_frames.push_back(mkf(2'b00, 8'h40));
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h40; req_wdata = 8'h77;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ss_n", {31'd0, SS_n}, 32'd1);
        check("abort_mosi", {31'd0, MOSI}, 32'd0);
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        exp_frames.push_back(mkf(2'b00, 8'h40)); exp_frames.push_back(mkf(2'b01, 8'h99));
        issue(1'b1, 8'h40, 8'h99, 31, 1'b0);
        exp_frames.push_back(mkf(2'b10, 8'h40)); exp_frames.push_back(mkf(2'b11, 8'h00));
        exp_rsp.push_back(8'h99);
        issue(1'b0, 8'h40, 8'h00, 41, 1'b0);

        // 5: repeated write address
        exp_frames.push_back(mkf(2'b00, 8'h10)); exp_frames.push_back(mkf(2'b01, 8'h11));
        issue(1'b1, 8'h10, 8'h11, 31, 1'b0);
`ifdef SPI_SEQ_ADDR_CACHE_EN
        exp_frames.push_back(mkf(2'b01, 8'h22));
        issue(1'b1, 8'h10, 8'h22, 16, 1'b0);
`else
        exp_frames.push_back(mkf(2'b00, 8'h10)); exp_frames.push_back(mkf(2'b01, 8'h22));
        issue(1'b1, 8'h10, 8'h22, 31, 1'b0);
`endif
        exp_frames.push_back(mkf(2'b10, 8'h10)); exp_frames.push_back(mkf(2'b11, 8'h00));
        exp_rsp.push_back(8'h22);
        issue(1'b0, 8'h10, 8'h00, 41, 1'b0);
        exp_frames.push_back(mkf(2'b00, 8'h11)); exp_frames.push_back(mkf(2'b01, 8'h33));
        issue(1'b1, 8'h11, 8'h33, 31, 1'b0);

        // 6: GAP_CYCLES=1, READ_LAT=0 instance; cycle k is just after the k-th edge post-accept
        req_valid6 = 1'b1; req_wr6 = 1'b0; req_addr6 = 8'h05;
        @(posedge clk); #1 req_valid6 = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk); #1;
            if (k == 11) check("g6_last_addr_bit_ss", {31'd0, SS_n6}, 32'd0);
            if (k == 12) check("g6_one_cycle_gap", {31'd0, SS_n6}, 32'd1);
            if (k == 13) check("g6_data_frame_ss", {31'd0, SS_n6}, 32'd0);
            if (k >= 24 && k <= 31) MISO6 = pat6[31-k];
            if (k == 31) check("g6_rsp_not_yet", {31'd0, rsp_valid6}, 32'd0);
            if (k == 32) begin
                MISO6 = 1'b0;
                check("g6_rsp_valid", {31'd0, rsp_valid6}, 32'd1);
                check("g6_rsp_rdata", {24'd0, rsp_rdata6}, {24'd0, pat6});
                check("g6_busy_at_rsp", {31'd0, req_ready6}, 32'd0);
            end
            if (k == 33) check("g6_ready_latency33", {31'd0, req_ready6}, 32'd1);
        end

        repeat (5) @(posedge clk);
        #1;
        check("frames_drained", exp_frames.size(), 0);
        check("rsp_drained", exp_rsp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
